// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode constants, ALU command codes, branch command enum
// and default datapath widths for the decode stage.
package mips_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_EXE_CMD_W  = 4;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;
  localparam logic [5:0] OP_BEZ  = 6'd40;
  localparam logic [5:0] OP_BNE  = 6'd41;
  localparam logic [5:0] OP_JMP  = 6'd42;

  // NOP must stay 0: an all-zero ID/EX register is a bubble.
  localparam logic [3:0] EXE_NOP = 4'd0;
  localparam logic [3:0] EXE_ADD = 4'd1;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEZ  = 2'd1,
    BR_BNE  = 2'd2,
    BR_JMP  = 2'd3
  } br_cmd_t;

endpackage

// File: rtl/id_controller.sv
// id_controller: combinational opcode decoder producing the ALU command,
// memory/write-back enables, immediate select and branch command.
module id_controller import mips_pkg::*; #(
  parameter int unsigned EXE_CMD_W = DEF_EXE_CMD_W
) (
  input  logic [5:0]           opcode,
  output logic [EXE_CMD_W-1:0] exe_cmd,
  output logic                 wb_en,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic                 is_imm,
  output logic                 st_or_bne,
  output br_cmd_t              br_cmd
);

  // Opcode to control table; unknown opcodes decode like NOP.
  always_comb begin
    exe_cmd   = EXE_CMD_W'(EXE_NOP);
    wb_en     = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    is_imm    = 1'b0;
    st_or_bne = 1'b0;
    br_cmd    = BR_NONE;
    case (opcode)
      OP_ADD: begin
        exe_cmd = EXE_CMD_W'(EXE_ADD);
        wb_en   = 1'b1;
      end
      OP_ADDI: begin
        exe_cmd = EXE_CMD_W'(EXE_ADD);
        wb_en   = 1'b1;
        is_imm  = 1'b1;
      end
      OP_LD: begin
        exe_cmd  = EXE_CMD_W'(EXE_ADD);
        wb_en    = 1'b1;
        mem_r_en = 1'b1;
        is_imm   = 1'b1;
      end
      OP_ST: begin
        exe_cmd   = EXE_CMD_W'(EXE_ADD);
        mem_w_en  = 1'b1;
        is_imm    = 1'b1;
        st_or_bne = 1'b1;
      end
      OP_BEZ: br_cmd = BR_BEZ;
      OP_BNE: begin
        br_cmd    = BR_BNE;
        st_or_bne = 1'b1;
      end
      OP_JMP: br_cmd = BR_JMP;
      default: ;
    endcase
  end

endmodule

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: MIPS ID stage with register-file addressing, branch
// resolution, load-use hazard detection and the registered ID/EX stage.
// Optional macro ID_BR_HAZARD_EN: branches stall until their sources are
// no longer pending in ID/EX or the shadow stage one cycle later.
module id_decode_pipe import mips_pkg::*; #(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned EXE_CMD_W  = DEF_EXE_CMD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     reg1,
  input  logic [DATA_W-1:0]     reg2,
  input  logic                  ex_stall,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2_reg_file,
  output logic                  stall_out,
  output logic                  br_taken,
  output logic [DATA_W-1:0]     br_offset,
  output logic                  id_ex_valid,
  output logic                  id_ex_wb_en,
  output logic                  id_ex_mem_r_en,
  output logic                  id_ex_mem_w_en,
  output logic [EXE_CMD_W-1:0]  id_ex_exe_cmd,
  output logic [DATA_W-1:0]     id_ex_val1,
  output logic [DATA_W-1:0]     id_ex_val2,
  output logic [DATA_W-1:0]     id_ex_st_val,
  output logic [REG_ADDR_W-1:0] id_ex_dest,
  output logic [REG_ADDR_W-1:0] id_ex_src1,
  output logic [REG_ADDR_W-1:0] id_ex_src2
);

  logic [REG_ADDR_W-1:0] dest_f, src1_f, src2_f;
  logic [DATA_W-1:0]     imm_ext;
  logic [EXE_CMD_W-1:0]  exe_cmd;
  logic                  wb_en, mem_r_en, mem_w_en, is_imm, st_or_bne;
  br_cmd_t               br_cmd;
  logic                  alu_op, use_src1, use_src2;
  logic                  br_cond, load_use, br_hazard, issue;

  assign dest_f = REG_ADDR_W'(instruction[25:21]);
  assign src1_f = REG_ADDR_W'(instruction[20:16]);
  assign src2_f = REG_ADDR_W'(instruction[15:11]);

  assign imm_ext       = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign br_offset     = imm_ext;
  assign src1          = src1_f;
  assign src2_reg_file = st_or_bne ? dest_f : src2_f;

  id_controller #(.EXE_CMD_W(EXE_CMD_W)) u_ctrl (
    .opcode    (instruction[31:26]),
    .exe_cmd   (exe_cmd),
    .wb_en     (wb_en),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .is_imm    (is_imm),
    .st_or_bne (st_or_bne),
    .br_cmd    (br_cmd)
  );

  // Which register ports the current instruction actually reads.
  assign alu_op   = (exe_cmd != EXE_CMD_W'(EXE_NOP));
  assign use_src1 = alu_op | (br_cmd == BR_BEZ) | (br_cmd == BR_BNE);
  assign use_src2 = (alu_op & ~is_imm) | st_or_bne;

  // Branch condition on the raw register-file read data.
  always_comb begin
    br_cond = 1'b0;
    case (br_cmd)
      BR_BEZ:  br_cond = (reg1 == '0);
      BR_BNE:  br_cond = (reg1 != reg2);
      BR_JMP:  br_cond = 1'b1;
      default: br_cond = 1'b0;
    endcase
  end

  assign load_use = if_valid & id_ex_valid & id_ex_mem_r_en & (id_ex_dest != '0) &
                    ((use_src1 & (id_ex_dest == src1_f)) |
                     (use_src2 & (id_ex_dest == src2_reg_file)));

`ifdef ID_BR_HAZARD_EN
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb;
  logic                  ex_wr, mem_wr;

  assign ex_wr  = id_ex_valid & id_ex_wb_en & (id_ex_dest != '0);
  assign mem_wr = mem_wb & (mem_dest != '0);

  assign br_hazard = if_valid & (
    (((br_cmd == BR_BEZ) | (br_cmd == BR_BNE)) &
      ((ex_wr & (id_ex_dest == src1_f)) | (mem_wr & (mem_dest == src1_f)))) |
    ((br_cmd == BR_BNE) &
      ((ex_wr & (id_ex_dest == src2_reg_file)) | (mem_wr & (mem_dest == src2_reg_file)))));

  // Shadow of ID/EX write-back info, one stage later; holds with the pipe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_dest <= '0;
      mem_wb   <= 1'b0;
    end else if (!ex_stall) begin
      mem_dest <= id_ex_dest;
      mem_wb   <= id_ex_valid & id_ex_wb_en;
    end
  end
`else
  assign br_hazard = 1'b0;
`endif

  assign stall_out = ex_stall | (if_valid & (load_use | br_hazard));
  assign br_taken  = if_valid & br_cond & ~stall_out;
  assign issue     = if_valid & ~load_use & ~br_hazard;

  // ID/EX register: reset and bubbles share the clear path; ex_stall holds.
  always_ff @(posedge clk) begin
    if (!rst || (!ex_stall && !issue)) begin
      id_ex_valid    <= 1'b0;
      id_ex_wb_en    <= 1'b0;
      id_ex_mem_r_en <= 1'b0;
      id_ex_mem_w_en <= 1'b0;
      id_ex_exe_cmd  <= '0;
      id_ex_val1     <= '0;
      id_ex_val2     <= '0;
      id_ex_st_val   <= '0;
      id_ex_dest     <= '0;
      id_ex_src1     <= '0;
      id_ex_src2     <= '0;
    end else if (!ex_stall) begin
      id_ex_valid    <= 1'b1;
      id_ex_wb_en    <= wb_en;
      id_ex_mem_r_en <= mem_r_en;
      id_ex_mem_w_en <= mem_w_en;
      id_ex_exe_cmd  <= exe_cmd;
      id_ex_val1     <= reg1;
      id_ex_val2     <= is_imm ? imm_ext : reg2;
      id_ex_st_val   <= reg2;
      id_ex_dest     <= dest_f;
      id_ex_src1     <= src1_f;
      id_ex_src2     <= is_imm ? '0 : src2_reg_file;
    end
  end

endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed and randomized checks of id_decode_pipe
// against an instruction-level reference model.
`timescale 1ns/1ps
module tb_id_decode_pipe;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, if_valid, ex_stall;
  logic [31:0] instruction, reg1, reg2;
  logic [4:0]  src1, src2_reg_file;
  logic        stall_out, br_taken;
  logic [31:0] br_offset;
  logic        id_ex_valid, id_ex_wb_en, id_ex_mem_r_en, id_ex_mem_w_en;
  logic [3:0]  id_ex_exe_cmd;
  logic [31:0] id_ex_val1, id_ex_val2, id_ex_st_val;
  logic [4:0]  id_ex_dest, id_ex_src1, id_ex_src2;

  always #5 clk = ~clk;

  id_decode_pipe #(.DATA_W(32), .REG_ADDR_W(5), .EXE_CMD_W(4)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instruction(instruction),
    .reg1(reg1), .reg2(reg2), .ex_stall(ex_stall),
    .src1(src1), .src2_reg_file(src2_reg_file), .stall_out(stall_out),
    .br_taken(br_taken), .br_offset(br_offset),
    .id_ex_valid(id_ex_valid), .id_ex_wb_en(id_ex_wb_en),
    .id_ex_mem_r_en(id_ex_mem_r_en), .id_ex_mem_w_en(id_ex_mem_w_en),
    .id_ex_exe_cmd(id_ex_exe_cmd), .id_ex_val1(id_ex_val1),
    .id_ex_val2(id_ex_val2), .id_ex_st_val(id_ex_st_val),
    .id_ex_dest(id_ex_dest), .id_ex_src1(id_ex_src1), .id_ex_src2(id_ex_src2)
  );

  typedef struct packed {
    logic        valid, wb, mr, mw;
    logic [3:0]  cmd;
    logic [31:0] v1, v2, sv;
    logic [4:0]  d, s1, s2;
  } idex_t;

  idex_t      m;
  logic [4:0] sh_d;
  logic       sh_wb;
  bit         known = 1'b0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] rf2_of(input logic [31:0] i);
    return (i[31:26] inside {OP_ST, OP_BNE}) ? i[25:21] : i[15:11];
  endfunction

`ifdef ID_BR_HAZARD_EN
  function automatic bit pend(input logic [4:0] r);
    return (r != 0) && ((m.valid && m.wb && m.d == r) || (sh_wb && sh_d == r));
  endfunction
`endif

  task automatic model_comb(output bit lu, output bit bh, output bit stall, output bit taken);
    logic [5:0] op = instruction[31:26];
    logic [4:0] s1 = instruction[20:16];
    logic [4:0] s2 = rf2_of(instruction);
    bit u1 = op inside {OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_BEZ, OP_BNE};
    bit u2 = op inside {OP_ADD, OP_ST, OP_BNE};
    bit cond;
    lu = if_valid && m.valid && m.mr && (m.d != 0) &&
         ((u1 && m.d == s1) || (u2 && m.d == s2));
    bh = 1'b0;
`ifdef ID_BR_HAZARD_EN
    if (if_valid && (op inside {OP_BEZ, OP_BNE}))
      bh = pend(s1) || (op == OP_BNE && pend(s2));
`endif
    cond  = (op == OP_BEZ && reg1 == 0) || (op == OP_BNE && reg1 != reg2) || (op == OP_JMP);
    stall = ex_stall || (if_valid && (lu || bh));
    taken = if_valid && cond && !stall;
  endtask

  function automatic idex_t decoded();
    idex_t d;
    logic [5:0] op = instruction[31:26];
    bit imm = op inside {OP_ADDI, OP_LD, OP_ST};
    d.valid = 1'b1;
    d.wb    = op inside {OP_ADD, OP_ADDI, OP_LD};
    d.mr    = (op == OP_LD);
    d.mw    = (op == OP_ST);
    d.cmd   = (op inside {OP_ADD, OP_ADDI, OP_LD, OP_ST}) ? EXE_ADD : EXE_NOP;
    d.v1    = reg1;
    d.v2    = imm ? 32'($signed(instruction[15:0])) : reg2;
    d.sv    = reg2;
    d.d     = instruction[25:21];
    d.s1    = instruction[20:16];
    d.s2    = imm ? 5'd0 : rf2_of(instruction);
    return d;
  endfunction

  // One clock: combinational checks at negedge, registered checks after posedge.
  task automatic cyc();
    bit lu, bh, st, tk;
    @(negedge clk);
    model_comb(lu, bh, st, tk);
    chk("src1", 32'(src1), 32'(instruction[20:16]));
    chk("src2_reg_file", 32'(src2_reg_file), 32'(rf2_of(instruction)));
    chk("br_offset", br_offset, 32'($signed(instruction[15:0])));
    if (known) begin
      chk("stall_out", 32'(stall_out), 32'(st));
      chk("br_taken", 32'(br_taken), 32'(tk));
    end
    @(posedge clk);
    #1;
    if (!rst) begin
      m = '0; sh_d = '0; sh_wb = 1'b0; known = 1'b1;
    end else if (!ex_stall) begin
      sh_d  = m.d;
      sh_wb = m.valid && m.wb;
      m     = (!if_valid || lu || bh) ? idex_t'('0) : decoded();
    end
    if (known) begin
      chk("id_ex_valid", 32'(id_ex_valid), 32'(m.valid));
      chk("id_ex_wb_en", 32'(id_ex_wb_en), 32'(m.wb));
      chk("id_ex_mem_r_en", 32'(id_ex_mem_r_en), 32'(m.mr));
      chk("id_ex_mem_w_en", 32'(id_ex_mem_w_en), 32'(m.mw));
      chk("id_ex_exe_cmd", 32'(id_ex_exe_cmd), 32'(m.cmd));
      chk("id_ex_val1", id_ex_val1, m.v1);
      chk("id_ex_val2", id_ex_val2, m.v2);
      chk("id_ex_st_val", id_ex_st_val, m.sv);
      chk("id_ex_dest", 32'(id_ex_dest), 32'(m.d));
      chk("id_ex_src1", 32'(id_ex_src1), 32'(m.s1));
      chk("id_ex_src2", 32'(id_ex_src2), 32'(m.s2));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [9] = '{OP_NOP, OP_ADD, OP_ADDI, OP_LD, OP_ST, OP_BEZ, OP_BNE, OP_JMP, 6'd17};
    logic [31:0] i = $urandom;
    i[31:26] = ops[$urandom_range(0, 8)];
    i[25:21] = 5'($urandom_range(0, 7));
    i[20:16] = 5'($urandom_range(0, 7));
    i[15:11] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  function automatic logic [31:0] rand_reg();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd3;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset with random inputs
    rst = 1'b0; ex_stall = 1'b0; if_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      instruction = rand_instr(); reg1 = rand_reg(); reg2 = rand_reg();
      cyc();
    end
    chk("rst_valid", 32'(id_ex_valid), 0);
    chk("rst_wb", 32'(id_ex_wb_en), 0);
    chk("rst_mr", 32'(id_ex_mem_r_en), 0);
    chk("rst_val1", id_ex_val1, 0);
    chk("rst_dest", 32'(id_ex_dest), 0);

    // ADDI r3, r1, 5
    rst = 1'b1;
    instruction = {OP_ADDI, 5'd3, 5'd1, 16'd5}; reg1 = 32'd10; reg2 = $urandom;
    cyc();
    chk("addi_valid", 32'(id_ex_valid), 1);
    chk("addi_val1", id_ex_val1, 10);
    chk("addi_val2", id_ex_val2, 5);
    chk("addi_src2", 32'(id_ex_src2), 0);
    chk("addi_wb", 32'(id_ex_wb_en), 1);

    // LD r4 then ADD r5, r4, r2: one bubble
    instruction = {OP_LD, 5'd4, 5'd1, 16'd8};
    cyc();
    instruction = {OP_ADD, 5'd5, 5'd4, 5'd2, 11'd0};
    #1 chk("lu_stall", 32'(stall_out), 1);
    cyc();
    chk("lu_bubble", 32'(id_ex_valid), 0);
    #1 chk("lu_clear", 32'(stall_out), 0);
    cyc();
    chk("lu_issue_valid", 32'(id_ex_valid), 1);
    chk("lu_issue_src1", 32'(id_ex_src1), 4);

    // BNE r1, r2
    instruction = {OP_BNE, 5'd2, 5'd1, 16'hFFFC}; reg1 = 32'd3; reg2 = 32'd3;
    #1 chk("bne_eq", 32'(br_taken), 0);
    reg2 = 32'd4;
    #1 chk("bne_ne", 32'(br_taken), 1);
    chk("bne_offset", br_offset, 32'hFFFF_FFFC);
    cyc();

    // ex_stall held 3 cycles
    instruction = {OP_ADD, 5'd6, 5'd1, 5'd2, 11'd0}; reg1 = 32'd11; reg2 = 32'd22;
    cyc();
    ex_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instruction = (k == 0) ? {OP_ADD, 5'd6, 5'd1, 5'd2, 11'd0} : {OP_JMP, 26'h0000040};
      reg1 = $urandom; reg2 = $urandom;
      #1 chk("exs_stall", 32'(stall_out), 1);
      chk("exs_br", 32'(br_taken), 0);
      cyc();
      chk("exs_val1", id_ex_val1, 11);
      chk("exs_val2", id_ex_val2, 22);
      chk("exs_dest", 32'(id_ex_dest), 6);
    end
    ex_stall = 1'b0;

    // ADD r7 then BEZ r7
    instruction = {OP_ADD, 5'd7, 5'd1, 5'd2, 11'd0}; reg1 = 32'd1; reg2 = 32'd2;
    cyc();
    instruction = {OP_BEZ, 5'd0, 5'd7, 16'h0010}; reg1 = 32'd0;
`ifdef ID_BR_HAZARD_EN
    for (int k = 0; k < 2; k++) begin
      #1 chk("bh_stall", 32'(stall_out), 1);
      chk("bh_br", 32'(br_taken), 0);
      cyc();
      chk("bh_bubble", 32'(id_ex_valid), 0);
    end
`endif
    #1 chk("bez_stall", 32'(stall_out), 0);
    chk("bez_taken", 32'(br_taken), 1);
    cyc();

    // Register 0 never hazards
    instruction = {OP_LD, 5'd0, 5'd1, 16'd4};
    cyc();
    instruction = {OP_ADD, 5'd5, 5'd0, 5'd0, 11'd0};
    #1 chk("r0_stall", 32'(stall_out), 0);
    cyc();
    chk("r0_valid", 32'(id_ex_valid), 1);

    // Reset during a load-use stall
    instruction = {OP_LD, 5'd4, 5'd1, 16'd0};
    cyc();
    instruction = {OP_ADD, 5'd5, 5'd4, 5'd4, 11'd0};
    #1 chk("mrst_stall", 32'(stall_out), 1);
    rst = 1'b0;
    cyc();
    chk("mrst_valid", 32'(id_ex_valid), 0);
    chk("mrst_mr", 32'(id_ex_mem_r_en), 0);
    rst = 1'b1;
    #1 chk("mrst_clear", 32'(stall_out), 0);
    cyc();
    chk("mrst_issue", 32'(id_ex_valid), 1);

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      rst         = ($urandom_range(0, 39) != 0);
      if_valid    = ($urandom_range(0, 7) != 0);
      ex_stall    = ($urandom_range(0, 4) == 0);
      instruction = rand_instr();
      reg1        = rand_reg();
      reg2        = rand_reg();
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_decode_pipe.md
# id_decode_pipe

Parametrised decode stage for the 5-stage MIPS pipeline. It decodes the IF/ID instruction and drives register-file read addresses, and it resolves branches in ID with a one-cycle flush request. It detects load-use hazards internally and owns the registered ID/EX pipeline register with a valid bit and downstream stall support. It sits between the IF/ID register and the EXE stage and replaces the combinational decode plus separate ID/EX register pair.

## Interface
- DATA_W, 32, datapath / register width
- REG_ADDR_W, 5, register-file address width
- EXE_CMD_W, 4, ALU command width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  IF/ID instruction
- reg1, reg2  in  DATA_W  register-file read data for src1 / src2_reg_file
- ex_stall  in  1  downstream hold; ID/EX must not change
- src1, src2_reg_file  out  REG_ADDR_W  combinational read addresses
- stall_out  out  1  hold PC and IF/ID
- br_taken  out  1  branch/jump taken; IF flushes IF/ID
- br_offset  out  DATA_W  sign-extended instruction[15:0]
- id_ex_valid, id_ex_wb_en, id_ex_mem_r_en, id_ex_mem_w_en  out  1  registered controls
- id_ex_exe_cmd  out  EXE_CMD_W
- id_ex_val1, id_ex_val2, id_ex_st_val  out  DATA_W  operand A, operand B (reg or imm), store data
- id_ex_dest, id_ex_src1, id_ex_src2  out  REG_ADDR_W  forwarding tags; id_ex_src2 = 0 when immediate

## Operation
- Fields: opcode [31:26], dest [25:21], src1 [20:16], src2 [15:11], imm [15:0].
- src2_reg_file = [25:21] for ST/BNE, else [15:11].
- Opcodes (mips_pkg): ADD 1, ADDI 32, LD 36, ST 37, BEZ 40, BNE 41, JMP 42. NOP 0 decodes to all controls 0.
- Branch: BEZ taken if reg1==0; BNE taken if reg1!=reg2; JMP always taken.
- br_taken = if_valid & branch_cond & !stall_out. Branches and ST write no register: wb_en=0.
- Load-use: stall when id_ex_valid & id_ex_mem_r_en & id_ex_dest!=0 & id_ex_dest matches a used source of the current instruction (src1; src2_reg_file when used).
- On a load-use stall, ID/EX loads a bubble: valid=0, all controls 0. stall_out=1.
- ex_stall=1: ID/EX holds all fields, stall_out=1, br_taken=0. This has priority over load-use and branch.
- Issue: when no stall and if_valid=1, ID/EX captures the decoded instruction with valid=1. When if_valid=0, ID/EX loads a bubble.
- Internal shadow register mem_dest/mem_wb tracks ID/EX dest/wb_en one stage later, advancing whenever ex_stall=0. Used only under ID_BR_HAZARD_EN.

## Timing
- Decode, read addresses, br_taken and stall_out are combinational in the same cycle.
- ID/EX outputs update on the clk edge: latency 1.
- Reset (rst=0 at edge): all id_ex_* = 0 and shadow = 0. Combinational outputs follow the inputs. Reset mid-stall clears the bubble and hold state at once.
- Load-use costs exactly one bubble. The next cycle, the load sits in EX/MEM and the hazard clears.
- Load-use coinciding with a branch in ID: the stall wins and the branch is evaluated the cycle after.
- Register 0 never produces a hazard.

## Configuration
- ID_BR_HAZARD_EN defined: a branch in ID stalls (bubble, stall_out=1) while any source it reads equals a nonzero wb_en dest in ID/EX or in the shadow stage. Branch compares therefore always see committed values; this costs up to 2 stall cycles.
- Not defined: the shadow register is removed. Branches compare raw reg1/reg2, and software guarantees spacing.

## Structure
- mips_pkg holds the opcode constants, EXE_CMD codes, branch-command enum (NONE, BEZ, BNE, JMP) and default widths.
- One sub-module, id_controller: a combinational opcode → {exe_cmd, wb_en, mem_r_en, mem_w_en, is_imm, st_or_bne, br_cmd}.
- Hazard logic, sign extension and the ID/EX register stay in the top.

## Test plan
- Reset: rst=0 for 2 cycles with random inputs → all id_ex_* = 0. After release, ADDI r3,r1,5 (reg1=10) → next cycle id_ex_valid=1, val1=10, val2=5, id_ex_src2=0, wb_en=1.
- Load-use: LD r4 followed by ADD r5,r4,r2 → one cycle with stall_out=1 and bubble (valid=0). ADD then issues with id_ex_src1=4.
- BNE with reg1=3, reg2=3 → br_taken=0. With reg2=4 → br_taken=1 and br_offset = sign-extended 0xFFFC = 0xFFFFFFFC.
- ex_stall held 3 cycles with ADD in ID → ID/EX unchanged, stall_out=1, br_taken=0 for a JMP present during that time.
- ID_BR_HAZARD_EN: ADD r7 then BEZ r7 → 2 stall cycles, then the branch resolves. Without the macro → resolves immediately, no stall.
- Register 0: LD r0 then ADD using r0 → no stall.
